// File: rtl/leds_line_ctrl_if.sv
// leds_line_ctrl_if
//   Word handshake between the display-word producer (master) and the
//   LED line sequencer (slave).
//   word_in    : display word, sampled on the accepting edge
//   word_valid : producer has a word; held until accepted
//   word_ready : sequencer can accept a word
interface leds_line_ctrl_if #(
  parameter int WORD_WIDTH = 18
);
  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_valid;
  logic                  word_ready;

  modport master (output word_in, output word_valid, input  word_ready);
  modport slave  (input  word_in, input  word_valid, output word_ready);
endinterface

// File: rtl/leds_line_ctrl.sv
// leds_line_ctrl
//   Serializes a parallel display word MSB-first into the LED line shift
//   register, then holds off for T_WIDTH cycles so the display stays legible.
//   Ports:
//     clk, rstn     : system clock, asynchronous active-low reset
//     w (slave)     : word_in / word_valid / word_ready handshake
//     line_din      : serial bit to the LED line register
//     line_din_ena  : one-cycle shift strobe to the LED line register
//     busy          : high while shifting or holding off
//     done          : one-cycle pulse in the cycle after the final strobe
//     frame_cnt     : completed frames, wraps 255 -> 0
//   All outputs are registered. word_ready is itself registered, so a word
//   offered while ready is high is taken on the following edge.
module leds_line_ctrl #(
  parameter int WORD_WIDTH = 18,
  parameter int SHIFT_DIV  = 1,
  parameter int T_WIDTH    = 10000
) (
  input  logic                  clk,
  input  logic                  rstn,
  leds_line_ctrl_if.slave       w,
  output logic                  line_din,
  output logic                  line_din_ena,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            frame_cnt
);
  localparam int IW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int HW = (T_WIDTH > 0) ? $clog2(T_WIDTH + 1) : 1;

  localparam logic [IW-1:0] IDX_TOP   = IW'(WORD_WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SHIFT_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((T_WIDTH > 0) ? T_WIDTH - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

  state_t                state_q,  state_d;
  logic [WORD_WIDTH-1:0] shadow_q, shadow_d;
  logic [IW-1:0]         idx_q,    idx_d;
  logic [DW-1:0]         div_q,    div_d;
  logic [HW-1:0]         hold_q,   hold_d;
  logic                  last_q,   last_d;   // index-0 strobe is on the line now
  logic                  ready_q,  ready_d;
  logic                  din_q,    din_d;
  logic                  ena_q,    ena_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic [7:0]            fcnt_q,   fcnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      div_q    <= '0;
      hold_q   <= '0;
      last_q   <= 1'b0;
      ready_q  <= 1'b1;
      din_q    <= 1'b0;
      ena_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      div_q    <= div_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      ready_q  <= ready_d;
      din_q    <= din_d;
      ena_q    <= ena_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    div_d    = div_q;
    hold_d   = hold_q;
    last_d   = last_q;
    ready_d  = ready_q;
    din_d    = din_q;     // line_din keeps its last value between strobes
    ena_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fcnt_d   = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (w.word_valid && ready_q) begin
          shadow_d = w.word_in;
          idx_d    = IDX_TOP;
          div_d    = '0;
          last_d   = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_q) begin
          // cycle after the final strobe: frame complete
          last_d = 1'b0;
          done_d = 1'b1;
          fcnt_d = fcnt_q + 8'd1;
          hold_d = '0;
          if (T_WIDTH == 0) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_HOLD;
          end
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          ena_d = 1'b1;
          din_d = shadow_q[idx_q];
          if (idx_q == '0) last_d = 1'b1;
          else             idx_d  = idx_q - IW'(1);
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_HOLD: begin
        // the done cycle is hold count 0, so T_WIDTH cycles in total
        if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign w.word_ready  = ready_q;
  assign line_din      = din_q;
  assign line_din_ena  = ena_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frame_cnt     = fcnt_q;
endmodule

// File: tb/tb_leds_line_ctrl.sv
// tb_leds_line_ctrl
//   Three sequencer instances (SHIFT_DIV/T_WIDTH = 1/4, 3/4, 1/0), each
//   driving its own LED line register model. A frame-level reference model
//   predicts every output per cycle from the accept edge and the word.
module tb_leds_line_ctrl;
  localparam int W  = 18;
  localparam int NI = 3;

  function automatic int div_of(input int g); return (g == 1) ? 3 : 1; endfunction
  function automatic int tw_of(input int g);  return (g == 2) ? 0 : 4; endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rstn [NI];
  logic [W-1:0] win  [NI];
  logic         wv   [NI];
  logic         rdy  [NI];
  logic         din  [NI];
  logic         ena  [NI];
  logic         bsy  [NI];
  logic         dn   [NI];
  logic [7:0]   fcnt [NI];
  logic [W-1:0] led  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    leds_line_ctrl_if #(.WORD_WIDTH(W)) bus ();
    logic [W-1:0] line_reg;
    logic         rn;
    assign rn             = rstn[g];
    assign bus.word_in    = win[g];
    assign bus.word_valid = wv[g];
    assign rdy[g]         = bus.word_ready;
    assign led[g]         = line_reg;

    leds_line_ctrl #(
      .WORD_WIDTH(W),
      .SHIFT_DIV((g == 1) ? 3 : 1),
      .T_WIDTH((g == 2) ? 0 : 4)
    ) dut (
      .clk(clk), .rstn(rn), .w(bus.slave),
      .line_din(din[g]), .line_din_ena(ena[g]), .busy(bsy[g]),
      .done(dn[g]), .frame_cnt(fcnt[g])
    );

    // LED line register: shifts in on each strobe, cleared by the same reset
    always @(posedge clk or negedge rn)
      if (!rn)        line_reg <= '0;
      else if (ena[g]) line_reg <= {line_reg[W-2:0], din[g]};
  end

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input int idx);
    total++;
    bad++;
    $display("FAIL %s[%0d]: timed out", nm, idx);
  endtask

  // ---------------- reference model ----------------
  int           e0    [NI] = '{default: -1};  // accept edge of current frame
  logic [W-1:0] mw    [NI] = '{default: '0};  // word captured at that edge
  bit           xr    [NI] = '{default: 1'b1}; // predicted word_ready this cycle
  int           mfc   [NI] = '{default: 0};
  int           nstb  [NI] = '{default: 0};
  int           ndone [NI] = '{default: 0};

  always @(posedge clk)
    for (int g = 0; g < NI; g++) begin
      if (!rstn[g])               e0[g] = -1;
      else if (wv[g] && xr[g]) begin
        e0[g] = cyc + 1;          // cyc still holds the previous edge count
        mw[g] = win[g];
      end
    end

  // Frame timeline relative to accept edge E0 (rel = edges since E0):
  //   strobe k at rel = k*D (k = 1..W) carrying bit W-k
  //   done at rel = W*D+1, ready low for rel 0..W*D+T, busy = !ready
  always @(negedge clk)
    for (int g = 0; g < NI; g++) begin
      int d, t, rel;
      bit xe, xd;
      d = div_of(g);
      t = tw_of(g);
      if (!rstn[g]) begin
        mfc[g] = 0;
        xr[g]  = 1'b1;
        if (chk_on) begin
          chk("rst_ena", g, ena[g], 0);
          chk("rst_ready", g, rdy[g], 1);
        end
      end else begin
        rel   = (e0[g] < 0) ? -1 : cyc - e0[g];
        xe    = (rel > 0) && (rel <= W * d) && (rel % d == 0);
        xd    = (rel == W * d + 1);
        xr[g] = !((rel >= 0) && (rel <= W * d + t));
        if (xd)     mfc[g] = (mfc[g] + 1) % 256;
        if (ena[g]) nstb[g]++;
        if (dn[g])  ndone[g]++;
        if (chk_on) begin
          chk("ena", g, ena[g], xe);
          chk("done", g, dn[g], xd);
          chk("ready", g, rdy[g], xr[g]);
          chk("busy", g, bsy[g], !xr[g]);
          chk("frame_cnt", g, fcnt[g], mfc[g]);
          if (xe) chk("din", g, din[g], mw[g][W - rel / d]);
          if (xd) chk("led", g, led[g], mw[g]);
        end
      end
    end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int g, input logic [W-1:0] word, input bit keep, output int ea);
    int n = 0;
    @(negedge clk); #1;
    win[g] = word;
    wv[g]  = 1'b1;
    while (!rdy[g] && n < 3000) begin @(negedge clk); #1; n++; end
    if (!rdy[g]) begin
      fail_now("accept", g);
      wv[g] = 1'b0;
      ea = -1;
      return;
    end
    @(posedge clk); #1;
    ea = cyc;
    if (!keep) wv[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    @(negedge clk); #1;
    while (!(rdy[g] && !bsy[g]) && n < 3000) begin @(negedge clk); #1; n++; end
    if (!(rdy[g] && !bsy[g])) fail_now("idle", g);
  endtask

  task automatic do_reset(input int g);
    @(negedge clk); #1;
    rstn[g] = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rstn[g] = 1'b1;
  endtask

  typedef struct {
    int           g;
    logic [W-1:0] word;
    logic [W-1:0] seq;       // line_din bits in strobe order, first bit in MSB
    int           done_rel;
    int           rdy_rel;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int ea, ea2, n0, s0;
    logic [7:0] f0;

    tbl[0] = '{0, 18'h2A5C3, 18'b101010010111000011, 19, 23};
    tbl[1] = '{1, 18'h3FFFF, 18'h3FFFF, 55, 59};
    tbl[2] = '{2, 18'h00001, 18'h00001, 19, 19};
    tbl[3] = '{1, 18'h0C3A5, 18'h0C3A5, 55, 59};

    for (int g = 0; g < NI; g++) begin
      rstn[g] = 1'b0;
      wv[g]   = 1'b0;
      win[g]  = '0;
    end

    // reset state
    repeat (3) @(negedge clk);
    #1 chk_on = 1'b1;
    @(negedge clk); #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_din", g, din[g], 0);
      chk("rst_busy", g, bsy[g], 0);
      chk("rst_done", g, dn[g], 0);
      chk("rst_fcnt", g, fcnt[g], 0);
      chk("rst_led", g, led[g], 0);
    end
    @(posedge clk); #2;
    for (int g = 0; g < NI; g++) rstn[g] = 1'b1;

    // table-driven single frames
    for (int i = 0; i < 4; i++) begin
      int g, drel, rrel, ns;
      logic [W-1:0] seq;
      g  = tbl[i].g;
      f0 = fcnt[g];
      send(g, tbl[i].word, 1'b0, ea);
      drel = -1; rrel = -1; ns = 0; seq = '0;
      for (int k = 0; k < 100 && rrel < 0; k++) begin
        @(negedge clk); #1;
        if (ena[g]) begin seq = {seq[W-2:0], din[g]}; ns++; end
        if (dn[g] && drel < 0) drel = cyc - ea;
        if (rdy[g] && rrel < 0) rrel = cyc - ea;
      end
      chk("tbl_done_at", i, drel, tbl[i].done_rel);
      chk("tbl_ready_at", i, rrel, tbl[i].rdy_rel);
      chk("tbl_strobes", i, ns, W);
      chk("tbl_din_seq", i, seq, tbl[i].seq);
      chk("tbl_led", i, led[g], tbl[i].word);
      chk("tbl_fcnt", i, fcnt[g], 8'(f0 + 8'd1));
    end

    // valid held high across SHIFT/HOLD with a changed word
    send(0, 18'h12345, 1'b1, ea);
    send(0, 18'h2ABCD, 1'b0, ea2);
    // ready visible after edge E0+W+1+T, so the accepting edge is one later
    chk("held_accept_gap", 0, ea2 - ea, W * 1 + 1 + 4 + 1);
    wait_idle(0);
    chk("held_led", 0, led[0], 18'h2ABCD);

    // T_WIDTH=0 back-to-back
    s0 = nstb[2];
    send(2, 18'h00001, 1'b1, ea);
    send(2, 18'h20000, 1'b0, ea2);
    chk("b2b_accept_gap", 2, ea2 - ea, W + 2);
    wait_idle(2);
    chk("b2b_strobes", 2, nstb[2] - s0, 2 * W);
    chk("b2b_led", 2, led[2], 18'h20000);

    // reset at the 9th strobe
    begin
      int ns = 0;
      int k  = 0;
      send(0, 18'h3C3C3, 1'b0, ea);
      while (ns < 9 && k < 200) begin
        @(negedge clk); #1;
        if (ena[0]) ns++;
        k++;
      end
      if (ns < 9) fail_now("ninth_strobe", 0);
      rstn[0] = 1'b0;
      #1;
      chk("mid_rst_ena", 0, ena[0], 0);
      chk("mid_rst_din", 0, din[0], 0);
      chk("mid_rst_ready", 0, rdy[0], 1);
      chk("mid_rst_busy", 0, bsy[0], 0);
      chk("mid_rst_fcnt", 0, fcnt[0], 0);
      chk("mid_rst_led", 0, led[0], 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      rstn[0] = 1'b1;
      send(0, 18'h15A0F, 1'b0, ea);
      wait_idle(0);
      chk("post_rst_led", 0, led[0], 18'h15A0F);
      chk("post_rst_fcnt", 0, fcnt[0], 1);
    end

    // randomized traffic across all instances
    for (int i = 0; i < 30; i++) begin
      int g;
      g = $urandom_range(0, NI - 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(g, W'($urandom), 1'b0, ea);
    end
    for (int g = 0; g < NI; g++) wait_idle(g);

    // 256 back-to-back frames: frame_cnt wraps to 0
    do_reset(2);
    n0 = ndone[2];
    for (int i = 0; i < 256; i++) send(2, W'($urandom), (i < 255), ea);
    wait_idle(2);
    chk("wrap_done_count", 2, ndone[2] - n0, 256);
    chk("wrap_fcnt", 2, fcnt[2], 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog[0]: got timeout want finish");
    $fatal(1);
  end
endmodule
